// File: rtl/exe_frame_pkg.sv
// Shared types and constants for the exe_unit byte-frame sequencer.
// Holds the FSM state enum, frame constants and status-byte bit positions.
package exe_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_A,
        GET_B,
        EXEC,
        TX_RES,
        TX_STAT
    } state_t;

    localparam logic [3:0] SYNC_NIBBLE  = 4'hA;
    localparam int         STAT_ERR_BIT = 7;
    localparam logic [7:0] STAT_BAD_OP  = 8'h80;

    localparam int FLAG_OF = 3;
    localparam int FLAG_SF = 2;
    localparam int FLAG_BF = 1;
    localparam int FLAG_VF = 0;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/exe_frame_ctrl_timer.sv
// Inter-byte idle timer: counts cycles while enabled, clears on i_clr.
// Ports: i_clk, i_rst (sync, active high), i_clr, i_en, o_hit (count == TIMEOUT).
module frame_timeout_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_hit
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] cnt;

    assign o_hit = (cnt == LIMIT);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            cnt <= 8'd0;
        end else if (i_en && !o_hit) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/exe_frame_ctrl.sv
// Byte-frame sequencer: header/argA/argB in, drives exe_unit, returns result/status.
// Ports: rx byte stream in, tx byte stream out, exe_unit operands/result/flags, busy, error count.
module exe_frame_ctrl
    import exe_frame_pkg::*;
#(
    parameter int N        = 4,
    parameter int M        = 8,
    parameter int MAX_OPER = 10,
    parameter int TIMEOUT  = 255
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [7:0]   i_rx_data,
    input  logic         i_rx_valid,
    output logic         o_rx_ready,
    output logic [7:0]   o_tx_data,
    output logic         o_tx_valid,
    input  logic         i_tx_ready,
    output logic [N-1:0] o_oper,
    output logic [M-1:0] o_argA,
    output logic [M-1:0] o_argB,
    input  logic [M-1:0] i_result,
    input  logic         i_OF,
    input  logic         i_SF,
    input  logic         i_BF,
    input  logic         i_VF,
    output logic         o_busy,
    output logic [7:0]   o_err_cnt
);

    state_t state;
    state_t state_nxt;

    logic         bad_op;
    logic [M-1:0] res;
    logic [7:0]   stat;
    logic [7:0]   flag_byte;

    logic         rx_fire;
    logic         tx_fire;
    logic         in_get;
    logic         hit;
    logic         abort;
    logic         sync_ok;
    logic         op_over;
    logic         err_evt;
    logic [N-1:0] rx_op;

    assign rx_fire = i_rx_valid && o_rx_ready;
    assign tx_fire = o_tx_valid && i_tx_ready;
    assign in_get  = (state == GET_A) || (state == GET_B);
    assign sync_ok = (i_rx_data[7:4] == SYNC_NIBBLE);
    assign rx_op   = i_rx_data[N-1:0];
    assign op_over = (32'(rx_op) > 32'(MAX_OPER));

    // A byte landing on the limit cycle takes priority over the abort.
    assign abort   = in_get && hit && !rx_fire;

    assign err_evt = (rx_fire && (state == IDLE) && !sync_ok)
                   || ((state == EXEC) && bad_op)
                   || abort;

    always_comb begin
        flag_byte          = 8'h00;
        flag_byte[FLAG_OF] = i_OF;
        flag_byte[FLAG_SF] = i_SF;
        flag_byte[FLAG_BF] = i_BF;
        flag_byte[FLAG_VF] = i_VF;
    end

    frame_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (rx_fire || !in_get),
        .i_en  (in_get),
        .o_hit (hit)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (rx_fire && sync_ok) state_nxt = GET_A;
            GET_A:   if (rx_fire)            state_nxt = GET_B;
                     else if (hit)           state_nxt = IDLE;
            GET_B:   if (rx_fire)            state_nxt = EXEC;
                     else if (hit)           state_nxt = IDLE;
            EXEC:                            state_nxt = TX_RES;
            TX_RES:  if (tx_fire)            state_nxt = TX_STAT;
            TX_STAT: if (tx_fire)            state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    // Outputs are held low while reset is asserted.
    always_comb begin
        o_rx_ready = 1'b0;
        o_tx_valid = 1'b0;
        o_tx_data  = 8'h00;
        o_busy     = 1'b0;
        if (!i_rst) begin
            o_busy = (state != IDLE);
            unique case (state)
                IDLE, GET_A, GET_B: o_rx_ready = 1'b1;
                TX_RES: begin
                    o_tx_valid = 1'b1;
                    o_tx_data  = res;
                end
                TX_STAT: begin
                    o_tx_valid = 1'b1;
                    o_tx_data  = stat;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_oper    <= '0;
            o_argA    <= '0;
            o_argB    <= '0;
            bad_op    <= 1'b0;
            res       <= '0;
            stat      <= 8'h00;
            o_err_cnt <= 8'h00;
        end else begin
            if (abort) begin
                o_oper <= '0;
                o_argA <= '0;
                o_argB <= '0;
            end else if (rx_fire) begin
                unique case (state)
                    IDLE: begin
                        if (sync_ok) begin
                            o_oper <= rx_op;
                            bad_op <= op_over;
                        end
                    end
                    GET_A:   o_argA <= i_rx_data[M-1:0];
                    GET_B:   o_argB <= i_rx_data[M-1:0];
                    default: ;
                endcase
            end
            if (state == EXEC) begin
                if (bad_op) begin
                    res  <= '0;
                    stat <= STAT_BAD_OP;
                end else begin
                    res  <= i_result;
                    stat <= flag_byte;
                end
            end
            if (err_evt) begin
                o_err_cnt <= sat_inc(o_err_cnt);
            end
        end
    end

endmodule

// File: tb/tb_exe_frame_ctrl.sv
// Scoreboard bench for exe_frame_ctrl with a behavioural exe_unit stand-in.
// Expected tx bytes are queued when a frame is sent and popped on each tx transfer.
module tb_exe_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [3:0] oper;
    logic [7:0] arg_a;
    logic [7:0] arg_b;
    logic [7:0] result;
    logic       of_f, sf_f, bf_f, vf_f;
    logic       busy;
    logic [7:0] err_cnt;
    logic [3:0] stub_flags;

    int         n_run  = 0;
    int         n_fail = 0;
    int         exp_err = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    exe_frame_ctrl dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_rx_ready (rx_ready),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_oper     (oper),
        .o_argA     (arg_a),
        .o_argB     (arg_b),
        .i_result   (result),
        .i_OF       (of_f),
        .i_SF       (sf_f),
        .i_BF       (bf_f),
        .i_VF       (vf_f),
        .o_busy     (busy),
        .o_err_cnt  (err_cnt)
    );

    always_comb begin
        case (oper)
            4'd0:    result = arg_a + arg_b;
            4'd1:    result = arg_a ^ arg_b;
            4'd2:    result = ~(arg_a ^ arg_b);
            4'd4:    result = {arg_a[6:0], 1'b0};
            default: result = arg_a | arg_b;
        endcase
    end

    assign {of_f, sf_f, bf_f, vf_f} = stub_flags;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                chk("tx_unexp", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("tx_byte", 32'(tx_data), 32'(e));
            end
        end
    end

    // Call aligned 1ns after a rising edge; returns 1ns after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) chk("rx_stall", n, 0);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] h, input logic [7:0] a,
                              input logic [7:0] b, input logic [3:0] fl,
                              input logic [7:0] er, input logic [7:0] es);
        send_byte(h);
        send_byte(a);
        stub_flags = fl;
        exp_q.push_back(er);
        exp_q.push_back(es);
        send_byte(b);
        @(negedge clk);
        chk("exec_no_tv", tx_valid, 0);
        chk("exec_busy", busy, 1);
        @(negedge clk);
        chk("res_tv", tx_valid, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", n, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        tx_ready   = 1'b1;
        stub_flags = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_oper", oper, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rx_ready", rx_ready, 1);
        @(posedge clk);
        #1;

        send_frame(8'hA0, 8'h7F, 8'h01, 4'h6, 8'h80, 8'h06);
        wait_drain();
        chk("add_err", err_cnt, exp_err);

        send_frame(8'hA1, 8'hFF, 8'h00, 4'hC, 8'hFF, 8'h0C);
        send_frame(8'hA2, 8'h0F, 8'hF0, 4'h0, 8'h00, 8'h00);
        wait_drain();

        send_frame(8'hAC, 8'h11, 8'h22, 4'hF, 8'h00, 8'h80);
        exp_err++;
        chk("badop_err", err_cnt, exp_err);
        wait_drain();

        send_byte(8'h30);
        exp_err++;
        @(negedge clk);
        chk("sync_busy", busy, 0);
        chk("sync_err", err_cnt, exp_err);
        @(posedge clk);
        #1;
        send_frame(8'hA4, 8'h81, 8'h00, 4'h0, 8'h02, 8'h00);
        wait_drain();

        send_byte(8'hA0);
        send_byte(8'h05);
        repeat (255) @(posedge clk);
        #1;
        chk("to_busy_254", busy, 1);
        @(posedge clk);
        #1;
        exp_err++;
        chk("to_idle", busy, 0);
        chk("to_err", err_cnt, exp_err);
        chk("to_arga", arg_a, 0);
        chk("to_oper", oper, 0);
        send_frame(8'hA0, 8'h01, 8'h01, 4'h0, 8'h02, 8'h00);
        wait_drain();

        send_byte(8'hA0);
        send_byte(8'h05);
        repeat (255) @(posedge clk);
        #1;
        chk("late_busy", busy, 1);
        stub_flags = 4'h9;
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h09);
        send_byte(8'h03);
        chk("late_busy2", busy, 1);
        wait_drain();
        chk("late_err", err_cnt, exp_err);

        tx_ready = 1'b0;
        send_frame(8'hA1, 8'h3C, 8'h0F, 4'h5, 8'h33, 8'h05);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_data", tx_data, 8'h33);
            chk("bp_valid", tx_valid, 1);
            chk("bp_rx_ready", rx_ready, 0);
        end
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        wait_drain();

        for (int i = 0; i < 260; i++) send_byte(8'h30);
        exp_err = 255;
        chk("err_sat", err_cnt, exp_err);

        send_byte(8'hA0);
        send_byte(8'h11);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_rx_ready", rx_ready, 0);
        chk("mrst_tx_valid", tx_valid, 0);
        chk("mrst_tx_data", tx_data, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_oper", oper, 0);
        chk("mrst_arga", arg_a, 0);
        chk("mrst_argb", arg_b, 0);
        chk("mrst_err", err_cnt, 0);
        rst = 1'b0;
        exp_err = 0;
        @(negedge clk);
        chk("post_rst_ready", rx_ready, 1);
        chk("post_rst_busy", busy, 0);
        @(posedge clk);
        #1;

        send_frame(8'hA0, 8'h01, 8'h02, 4'h3, 8'h03, 8'h03);
        wait_drain();
        chk("final_err", err_cnt, exp_err);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
